// File: rtl/mips_pkg.sv
// Shared datapath types for the 16-bit MIPS core.
// Sizes the register file and its address/data buses.
package mips_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;

   typedef logic [DEPTH-1:0][DATA_W-1:0] reg_bank_t;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      word_t     data;
   } wr_req_t;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback-facing bus of the register file.
// The master drives addresses and write data; the slave returns read data.
interface register_file_if;
   import mips_pkg::*;

   logic      write_EN;
   reg_addr_t reg_write_add;
   word_t     reg_write_data;
   reg_addr_t reg1_read_add;
   word_t     reg1_read_data;
   reg_addr_t reg2_read_add;
   word_t     reg2_read_data;

   modport master (
      output write_EN,
      output reg_write_add,
      output reg_write_data,
      output reg1_read_add,
      output reg2_read_add,
      input  reg1_read_data,
      input  reg2_read_data
   );

   modport slave (
      input  write_EN,
      input  reg_write_add,
      input  reg_write_data,
      input  reg1_read_add,
      input  reg2_read_add,
      output reg1_read_data,
      output reg2_read_data
   );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: a DEPTH:1 DATA_W-wide selector over the register bank.
module rf_read_port
   import mips_pkg::*;
(
   input  reg_bank_t i_regs,
   input  reg_addr_t i_addr,
   output word_t     o_data
);

   // Every ADDR_W-bit address is in range, so no default or bounds check is needed.
   assign o_data = i_regs[i_addr];

endmodule

// File: rtl/register_file.sv
// Register file for the 16-bit MIPS datapath: one synchronous write port,
// two independent combinational read ports, no hard-wired zero register.
module register_file
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  rf
);

   reg_bank_t r_mem;
   wr_req_t   w_wr;
   word_t     w_rd1;
   word_t     w_rd2;

   assign w_wr.en   = rf.write_EN;
   assign w_wr.addr = rf.reg_write_add;
   assign w_wr.data = rf.reg_write_data;

   // Reset has priority, so writes presented while rst is high are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem <= '0;
      end else if (w_wr.en) begin
         r_mem[w_wr.addr] <= w_wr.data;
      end
   end

   // Reads come straight from storage: no bypass, a same-cycle write shows after the edge.
   rf_read_port u_read1 (
      .i_regs (r_mem),
      .i_addr (rf.reg1_read_add),
      .o_data (w_rd1)
   );

   rf_read_port u_read2 (
      .i_regs (r_mem),
      .i_addr (rf.reg2_read_add),
      .o_data (w_rd2)
   );

   assign rf.reg1_read_data = w_rd1;
   assign rf.reg2_read_data = w_rd2;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, fill, write-disable,
// read-during-write and dual-port sweep.
module tb_register_file;
   import mips_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   register_file_if rf ();

   register_file dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All input changes happen on the falling edge, half a cycle from the write edge.
   task automatic applyStimulus(input logic we, input reg_addr_t wa, input word_t wd,
                                input reg_addr_t a1, input reg_addr_t a2);
      @(negedge clk);
      rf.write_EN       = we;
      rf.reg_write_add  = wa;
      rf.reg_write_data = wd;
      rf.reg1_read_add  = a1;
      rf.reg2_read_add  = a2;
   endtask

   task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      word_t model [DEPTH];
      checks   = 0;
      failures = 0;

      rst               = 1'b1;
      rf.write_EN       = 1'b0;
      rf.reg_write_add  = '0;
      rf.reg_write_data = '0;
      rf.reg1_read_add  = 3'd0;
      rf.reg2_read_add  = 3'd7;
      #3;
      checkOutput("reset_r0", rf.reg1_read_data, 16'h0000);
      checkOutput("reset_r7", rf.reg2_read_data, 16'h0000);
      #9 rst = 1'b0;

      // Preload random contents so the mid-cycle reset has something to clear.
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = word_t'($urandom);
         applyStimulus(1'b1, reg_addr_t'(i), model[i], 3'd0, 3'd0);
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, 3'd5, 3'd6);
      #1;
      checkOutput("preload_r5", rf.reg1_read_data, model[5]);
      checkOutput("preload_r6", rf.reg2_read_data, model[6]);

      @(posedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < DEPTH / 2; i++) begin
         rf.reg1_read_add = reg_addr_t'(2 * i);
         rf.reg2_read_add = reg_addr_t'(2 * i + 1);
         #1;
         checkOutput($sformatf("async_reset_r%0d", 2 * i), rf.reg1_read_data, 16'h0000);
         checkOutput($sformatf("async_reset_r%0d", 2 * i + 1), rf.reg2_read_data, 16'h0000);
      end

      applyStimulus(1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3);
      @(posedge clk);
      #1;
      checkOutput("write_in_reset", rf.reg1_read_data, 16'h0000);
      applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
      rst = 1'b0;

      applyStimulus(1'b1, 3'd0, 16'hFEE5, 3'd0, 3'd1);
      applyStimulus(1'b1, 3'd1, 16'h5342, 3'd0, 3'd1);
      applyStimulus(1'b1, 3'd2, 16'hA334, 3'd0, 3'd1);
      applyStimulus(1'b1, 3'd3, 16'hAAE3, 3'd0, 3'd1);
      applyStimulus(1'b1, 3'd4, 16'h0BB5, 3'd0, 3'd1);
      applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd1);
      #1;
      checkOutput("fill_r0", rf.reg1_read_data, 16'hFEE5);
      checkOutput("fill_r1", rf.reg2_read_data, 16'h5342);
      rf.reg1_read_add = 3'd1;
      rf.reg2_read_add = 3'd2;
      #1;
      checkOutput("fill_p1_r1", rf.reg1_read_data, 16'h5342);
      checkOutput("fill_p2_r2", rf.reg2_read_data, 16'hA334);
      rf.reg1_read_add = 3'd3;
      rf.reg2_read_add = 3'd4;
      #1;
      checkOutput("fill_r3", rf.reg1_read_data, 16'hAAE3);
      checkOutput("fill_r4", rf.reg2_read_data, 16'h0BB5);

      applyStimulus(1'b0, 3'd1, 16'hFFFF, 3'd1, 3'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("wen_low_p1", rf.reg1_read_data, 16'h5342);
      checkOutput("wen_low_p2", rf.reg2_read_data, 16'h5342);

      applyStimulus(1'b1, 3'd2, 16'h1234, 3'd2, 3'd2);
      #1;
      checkOutput("rdw_before", rf.reg1_read_data, 16'hA334);
      @(posedge clk);
      #1;
      checkOutput("rdw_after", rf.reg1_read_data, 16'h1234);
      applyStimulus(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
      #1;
      checkOutput("dual_r3_p1", rf.reg1_read_data, 16'hAAE3);
      checkOutput("dual_r3_p2", rf.reg2_read_data, 16'hAAE3);

      // Sweep: register i holds 0x1111*(i+1); port 2 reads in reverse order.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, reg_addr_t'(i), word_t'(16'h1111 * (i + 1)), 3'd0, 3'd0);
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd7);
      for (int i = 0; i < DEPTH; i++) begin
         rf.reg1_read_add = reg_addr_t'(i);
         rf.reg2_read_add = reg_addr_t'(DEPTH - 1 - i);
         #1;
         checkOutput($sformatf("sweep_p1_r%0d", i), rf.reg1_read_data,
                     word_t'(16'h1111 * (i + 1)));
         checkOutput($sformatf("sweep_p2_r%0d", DEPTH - 1 - i), rf.reg2_read_data,
                     word_t'(16'h1111 * (DEPTH - i)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
